// File: rtl/fetch_pred_pkg.sv
// fetch_pred_pkg: constants and types shared by the fetch stage and its BTB.
//   CorePcw  - default PC / byte-address width
//   InstW    - instruction word width
//   PcInc    - sequential PC increment (bytes)
//   ResetPc  - fetch address after reset
//   ctr_e    - 2-bit saturating branch counter encodings
//   ctr_step - saturating counter update toward the resolved outcome
package fetch_pred_pkg;

    localparam int unsigned CorePcw = 13;
    localparam int unsigned InstW   = 32;
    localparam int unsigned PcInc   = 4;
    localparam int unsigned ResetPc = 0;

    typedef enum logic [1:0] {
        CtrSnt = 2'b00,
        CtrWnt = 2'b01,
        CtrWt  = 2'b10,
        CtrSt  = 2'b11
    } ctr_e;

    // Move one step toward the outcome, sticking at the strong states.
    function automatic ctr_e ctr_step(ctr_e ctr, logic taken);
        ctr_e res;
        if (taken) begin
            res = (ctr == CtrSt) ? CtrSt : ctr_e'(ctr + 2'd1);
        end else begin
            res = (ctr == CtrSnt) ? CtrSnt : ctr_e'(ctr - 2'd1);
        end
        return res;
    endfunction

endpackage

// File: rtl/fetch_pred_btb.sv
// btb_2bit: direct-mapped branch target buffer with 2-bit saturating counters.
//   clk_i, rst_i   - clock (rising edge), asynchronous active-high reset
//   lookup_pc_i    - PC being fetched; lookup is purely combinational
//   hit_o          - entry valid and tag matches
//   taken_o        - hit and counter in a taken state
//   target_o       - stored target on hit, else 0
//   upd_valid_i    - resolved branch/jump this cycle; train the entry
//   upd_pc_i       - PC of the resolved branch
//   upd_taken_i    - actual outcome
//   upd_target_i   - actual target
module btb_2bit
    import fetch_pred_pkg::*;
#(
    parameter int unsigned PCW  = CorePcw,
    parameter int unsigned IDXW = 4
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic [PCW-1:0] lookup_pc_i,
    output logic           hit_o,
    output logic           taken_o,
    output logic [PCW-1:0] target_o,
    input  logic           upd_valid_i,
    input  logic [PCW-1:0] upd_pc_i,
    input  logic           upd_taken_i,
    input  logic [PCW-1:0] upd_target_i
);

    localparam int unsigned TAGW    = PCW - IDXW - 2;
    localparam int unsigned Entries = 2 ** IDXW;

    logic [Entries-1:0] valid_q, valid_d;
    logic [TAGW-1:0]    tag_q [Entries];
    logic [TAGW-1:0]    tag_d [Entries];
    logic [PCW-1:0]     tgt_q [Entries];
    logic [PCW-1:0]     tgt_d [Entries];
    ctr_e               ctr_q [Entries];
    ctr_e               ctr_d [Entries];

    logic [IDXW-1:0] lk_idx;
    logic [TAGW-1:0] lk_tag;
    logic [IDXW-1:0] upd_idx;
    logic [TAGW-1:0] upd_tag;
    logic            upd_hit;
    logic [PCW-1:0]  upd_tgt_aligned;

    // Byte-offset bits never reach the fetch PC.
    logic unused_low_bits;
    assign unused_low_bits = ^{lookup_pc_i[1:0], upd_pc_i[1:0], upd_target_i[1:0]};

    assign lk_idx  = lookup_pc_i[IDXW+1:2];
    assign lk_tag  = lookup_pc_i[PCW-1:IDXW+2];
    assign upd_idx = upd_pc_i[IDXW+1:2];
    assign upd_tag = upd_pc_i[PCW-1:IDXW+2];

    // Targets are stored word-aligned so a predicted PC keeps pc[1:0] == 0.
    assign upd_tgt_aligned = {upd_target_i[PCW-1:2], 2'b00};

    assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

    // Lookup reads the pre-edge contents; same-cycle training shows next cycle.
    always_comb begin
        hit_o    = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
        taken_o  = hit_o && ctr_q[lk_idx][1];
        target_o = hit_o ? tgt_q[lk_idx] : '0;
    end

    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        tgt_d   = tgt_q;
        ctr_d   = ctr_q;
        if (upd_valid_i) begin
            if (upd_hit) begin
                ctr_d[upd_idx] = ctr_step(ctr_q[upd_idx], upd_taken_i);
                if (upd_taken_i) begin
                    tgt_d[upd_idx] = upd_tgt_aligned;
                end
            end else if (upd_taken_i) begin
                // Allocate on a taken miss, evicting whatever held this index.
                valid_d[upd_idx] = 1'b1;
                tag_d[upd_idx]   = upd_tag;
                tgt_d[upd_idx]   = upd_tgt_aligned;
                ctr_d[upd_idx]   = CtrWt;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= '0;
            for (int i = 0; i < Entries; i++) begin
                tag_q[i] <= '0;
                tgt_q[i] <= '0;
                ctr_q[i] <= CtrWnt;
            end
        end else begin
            valid_q <= valid_d;
            tag_q   <= tag_d;
            tgt_q   <= tgt_d;
            ctr_q   <= ctr_d;
        end
    end

endmodule

// File: rtl/fetch_pred.sv
// fetch_pred: RV32I fetch stage with BTB-based next-PC prediction.
//   CLK, RST      - clock (rising edge), asynchronous active-high reset
//   stall         - hold the PC
//   fail_predict  - redirect to redirect_pc (overrides stall)
//   redirect_pc   - correct next PC; low two bits are dropped
//   upd_*         - branch resolution from execute, trains the BTB
//   imem_addr     - instruction memory address (current PC)
//   imem_rdata    - instruction word, combinational read
//   pcF, instF    - current fetch PC and instruction
//   predF         - current instruction predicted taken
//   pred_tgtF     - predicted target (0 on BTB miss)
module fetch_pred
    import fetch_pred_pkg::*;
#(
    parameter int unsigned PCW  = CorePcw,
    parameter int unsigned IDXW = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             stall,
    input  logic             fail_predict,
    input  logic [PCW-1:0]   redirect_pc,
    input  logic             upd_valid,
    input  logic [PCW-1:0]   upd_pc,
    input  logic             upd_taken,
    input  logic [PCW-1:0]   upd_target,
    output logic [PCW-1:0]   imem_addr,
    input  logic [InstW-1:0] imem_rdata,
    output logic [PCW-1:0]   pcF,
    output logic [InstW-1:0] instF,
    output logic             predF,
    output logic [PCW-1:0]   pred_tgtF
);

    logic [PCW-1:0] pc_q, pc_d;
    logic           btb_hit;
    logic           btb_taken;
    logic [PCW-1:0] btb_target;

    logic unused_redirect_low;
    assign unused_redirect_low = ^redirect_pc[1:0];

    btb_2bit #(
        .PCW  (PCW),
        .IDXW (IDXW)
    ) u_btb (
        .clk_i        (CLK),
        .rst_i        (RST),
        .lookup_pc_i  (pc_q),
        .hit_o        (btb_hit),
        .taken_o      (btb_taken),
        .target_o     (btb_target),
        .upd_valid_i  (upd_valid),
        .upd_pc_i     (upd_pc),
        .upd_taken_i  (upd_taken),
        .upd_target_i (upd_target)
    );

    assign predF     = btb_hit & btb_taken;
    assign pred_tgtF = btb_target;
    assign pcF       = pc_q;
    assign imem_addr = pc_q;
    assign instF     = imem_rdata;

    // Redirect beats stall; a predicted-taken target is taken with no bubble.
    always_comb begin
        pc_d = pc_q;
        if (fail_predict) begin
            pc_d = {redirect_pc[PCW-1:2], 2'b00};
        end else if (stall) begin
            pc_d = pc_q;
        end else if (predF) begin
            pc_d = pred_tgtF;
        end else begin
            pc_d = pc_q + PCW'(PcInc);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pc_q <= PCW'(ResetPc);
        end else begin
            pc_q <= pc_d;
        end
    end

endmodule

// File: tb/tb_fetch_pred.sv
module tb_fetch_pred;

    localparam int unsigned PCW = 13;

    logic           CLK;
    logic           RST;
    logic           stall;
    logic           fail_predict;
    logic [PCW-1:0] redirect_pc;
    logic           upd_valid;
    logic [PCW-1:0] upd_pc;
    logic           upd_taken;
    logic [PCW-1:0] upd_target;
    logic [PCW-1:0] imem_addr;
    logic [31:0]    imem_rdata;
    logic [PCW-1:0] pcF;
    logic [31:0]    instF;
    logic           predF;
    logic [PCW-1:0] pred_tgtF;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    fetch_pred #(
        .PCW  (PCW),
        .IDXW (4)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .stall        (stall),
        .fail_predict (fail_predict),
        .redirect_pc  (redirect_pc),
        .upd_valid    (upd_valid),
        .upd_pc       (upd_pc),
        .upd_taken    (upd_taken),
        .upd_target   (upd_target),
        .imem_addr    (imem_addr),
        .imem_rdata   (imem_rdata),
        .pcF          (pcF),
        .instF        (instF),
        .predF        (predF),
        .pred_tgtF    (pred_tgtF)
    );

    // Instruction memory: word content encodes its own address.
    assign imem_rdata = 32'h1300_0000 | {19'd0, imem_addr};

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic expect_fetch(input string tag, input logic [PCW-1:0] pc, input logic pred,
                                input logic [PCW-1:0] tgt);
        check_eq({tag, ".pcF"}, 32'(pcF), 32'(pc));
        check_eq({tag, ".instF"}, instF, 32'h1300_0000 | 32'(pc));
        check_eq({tag, ".predF"}, 32'(predF), 32'(pred));
        check_eq({tag, ".tgt"}, 32'(pred_tgtF), 32'(tgt));
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Redirect fetch to pc on the next edge.
    task automatic go_to(input logic [PCW-1:0] pc);
        fail_predict = 1'b1;
        redirect_pc  = pc;
        tick();
        fail_predict = 1'b0;
    endtask

    task automatic train(input logic [PCW-1:0] pc, input logic taken, input logic [PCW-1:0] tgt);
        upd_valid  = 1'b1;
        upd_pc     = pc;
        upd_taken  = taken;
        upd_target = tgt;
        tick();
        upd_valid  = 1'b0;
    endtask

    initial begin
        RST          = 1'b1;
        stall        = 1'b0;
        fail_predict = 1'b0;
        redirect_pc  = '0;
        upd_valid    = 1'b0;
        upd_pc       = '0;
        upd_taken    = 1'b0;
        upd_target   = '0;

        #2;
        expect_fetch("reset", 13'h000, 1'b0, 13'h000);
        @(posedge CLK);
        #1;
        RST = 1'b0;

        // Sequential fetch after reset
        expect_fetch("seq0", 13'h000, 1'b0, 13'h000);
        tick();
        expect_fetch("seq1", 13'h004, 1'b0, 13'h000);
        tick();
        expect_fetch("seq2", 13'h008, 1'b0, 13'h000);
        tick();
        expect_fetch("seq3", 13'h00C, 1'b0, 13'h000);

        // Stall at 0x008, then redirect during stall
        go_to(13'h008);
        check_eq("redir8", 32'(pcF), 32'h008);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("stall_hold", 32'(pcF), 32'h008);
        end
        fail_predict = 1'b1;
        redirect_pc  = 13'h0102;
        tick();
        fail_predict = 1'b0;
        stall        = 1'b0;
        check_eq("redir_over_stall", 32'(pcF), 32'h100);

        // Allocate 0x010 -> 0x040, then fetch it
        train(13'h010, 1'b1, 13'h040);
        check_eq("train_seq", 32'(pcF), 32'h104);
        go_to(13'h010);
        expect_fetch("alloc_hit", 13'h010, 1'b1, 13'h040);
        tick();
        expect_fetch("pred_follow", 13'h040, 1'b0, 13'h000);

        // Saturate (10 -> 11 -> 11 -> 11); last update moves the target
        train(13'h010, 1'b1, 13'h040);
        train(13'h010, 1'b1, 13'h040);
        train(13'h010, 1'b1, 13'h060);
        train(13'h010, 1'b0, 13'h000);
        go_to(13'h010);
        expect_fetch("sat_then_nt", 13'h010, 1'b1, 13'h060);
        train(13'h010, 1'b0, 13'h000);
        check_eq("tgt_follow", 32'(pcF), 32'h060);
        go_to(13'h010);
        expect_fetch("decay_wnt", 13'h010, 1'b0, 13'h060);
        tick();
        check_eq("decay_next", 32'(pcF), 32'h014);

        // Tag conflict: 0x050 evicts 0x010
        train(13'h050, 1'b1, 13'h0A0);
        go_to(13'h010);
        expect_fetch("evicted", 13'h010, 1'b0, 13'h000);
        train(13'h090, 1'b0, 13'h0C0);
        go_to(13'h050);
        expect_fetch("nt_miss_keep", 13'h050, 1'b1, 13'h0A0);

        // Same-cycle lookup and update of the same entry (ctr 10 -> 01)
        upd_valid  = 1'b1;
        upd_pc     = 13'h050;
        upd_taken  = 1'b0;
        upd_target = 13'h000;
        tick();
        upd_valid  = 1'b0;
        check_eq("same_cycle_old", 32'(pcF), 32'h0A0);
        go_to(13'h050);
        check_eq("same_cycle_new", 32'(predF), 32'h0);

        // PC wrap
        go_to(13'h1FFC);
        expect_fetch("wrap_top", 13'h1FFC, 1'b0, 13'h000);
        tick();
        expect_fetch("wrap_zero", 13'h000, 1'b0, 13'h000);

        // Mid-run asynchronous reset clears PC and BTB
        train(13'h010, 1'b1, 13'h040);
        go_to(13'h010);
        expect_fetch("pre_rst", 13'h010, 1'b1, 13'h040);
        #1;
        RST = 1'b1;
        #1;
        expect_fetch("async_rst", 13'h000, 1'b0, 13'h000);
        #3;
        RST = 1'b0;
        go_to(13'h010);
        expect_fetch("post_rst", 13'h010, 1'b0, 13'h000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_pred.md
Name: fetch_pred

Overview:
- Fetch stage directly upstream of the fetch-to-C pipeline register of the RV32I core.
- Owns the program counter and drives the instruction-memory address.
- Presents pcF/instF plus a taken-prediction flag to the downstream register.
- Predicts branches with a direct-mapped BTB holding 2-bit saturating counters, trained from execute and redirected on misprediction.

Parameters:
- PCW, 13, PC/byte-address width.
- IDXW, 4, BTB index bits (2^IDXW entries).
- TAGW, PCW-IDXW-2, BTB tag bits (derived; not overridden).

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  reset, asynchronous, active-high.
- stall  in  1  hold PC (downstream hazard).
- fail_predict  in  1  misprediction detected in execute; redirect.
- redirect_pc  in  PCW  correct next PC on fail_predict.
- upd_valid  in  1  branch/jump resolved this cycle; train BTB.
- upd_pc  in  PCW  PC of resolved branch.
- upd_taken  in  1  actual outcome.
- upd_target  in  PCW  actual target.
- imem_addr  out  PCW  instruction memory address (= pc, combinational).
- imem_rdata  in  32  instruction word, combinational read.
- pcF  out  PCW  current fetch PC.
- instF  out  32  = imem_rdata.
- predF  out  1  current instruction predicted taken.
- pred_tgtF  out  PCW  predicted target (valid when predF=1).

Behaviour:
- Reset (RST high, async):
  - pc=0; all BTB valid=0, ctr=2'b01, target=0, tag=0.
  - pcF=0; predF=0; pred_tgtF=0.
- Lookup (combinational):
  - idx=pc[IDXW+1:2], tag=pc[PCW-1:IDXW+2].
  - hit = valid[idx] & tag match.
  - predF = hit & ctr[idx][1]; pred_tgtF = target[idx] if hit, else 0.
- Next-PC priority, registered on the CLK edge:
  - (1) fail_predict: pc <= {redirect_pc[PCW-1:2],2'b00}.
  - (2) stall: pc holds.
  - (3) predF: pc <= pred_tgtF.
  - (4) otherwise: pc <= pc+4, modulo 2^PCW (0x1FFC wraps to 0x0000).
  - fail_predict overrides stall.
- pc[1:0] is always 0.
- Latency:
  - Redirect is visible on pcF one cycle after fail_predict is sampled.
  - A predicted-taken target is on pcF in the next cycle: zero bubbles.
- BTB update, sampled on the edge when upd_valid=1, indexed/tagged from upd_pc:
  - Tag hit: ctr saturating +1 if upd_taken, else -1 (bounds 0 and 3).
    - If upd_taken, target <= upd_target.
  - Tag miss and upd_taken: allocate (overwrite). valid=1, tag set, target=upd_target, ctr=2'b10.
  - Tag miss and not taken: no change.
- Same-cycle lookup and update of the same entry: the lookup uses the pre-edge contents; the new state is visible from the next cycle.
- Update is independent of stall/fail_predict; it still occurs during either.
- RST asserted mid-operation: all state is cleared immediately and asynchronously. Fetch restarts at 0 on the first edge after release.

Decomposition:
- Shared core package holds:
  - PCW, the instruction width (32) and the PC increment (4).
  - The reset PC (0).
  - Counter encodings: SNT=00, WNT=01, WT=10, ST=11.
- Sub-module btb_2bit:
  - Storage arrays, combinational lookup and update logic.
  - Ports: lookup pc in; hit/taken/target out; upd_* in.
- fetch_pred instantiates btb_2bit and keeps the PC register and next-PC mux.

Test Plan:
- Reset, then 4 cycles with no stall -> pcF = 0x000, 0x004, 0x008, 0x00C; predF=0; instF tracks imem_rdata.
- stall=1 for 3 cycles at pcF=0x008, then fail_predict=1 with redirect_pc=0x0102 while stall=1 -> pcF holds 0x008 for 3 cycles, then 0x100 next cycle (low bits forced to 0).
- Training:
  - upd_valid, upd_pc=0x010, taken, target 0x040 -> entry allocated at ctr=10.
  - Next fetch of 0x010 -> predF=1, pred_tgtF=0x040, following pcF=0x040.
- Counter saturation and decay:
  - 3 taken updates on 0x010 -> ctr=11.
  - 2 not-taken updates -> ctr=01, and fetch at 0x010 gives predF=0, next pcF=0x014.
- Tag conflict:
  - 0x010 is allocated; a taken update for 0x050 (same idx) overwrites it.
  - Fetch 0x010 -> hit=0, predF=0.
  - A not-taken update for 0x090 on a miss leaves the entry unchanged.
- Edge cases:
  - pc=0x1FFC with no prediction -> next pcF=0x0000.
  - RST pulsed for a half cycle mid-run -> pcF=0 and predF=0 immediately; the previously trained 0x010 no longer predicts.
